// File: rtl/gnrc_rdstream_pkg.sv
// Shared types for the RAM read-stream engine: FSM states and credit counter sizing.
package gnrc_rdstream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  // Credits span 0..BUF_DP inclusive.
  function automatic int credit_w(input int buf_dp);
    return $clog2(buf_dp + 1);
  endfunction

endpackage

// File: rtl/gnrc_rdstream_buf.sv
// Output FIFO, head read combinationally (zero-latency view of the oldest word).
// Push while full is accepted only together with a pop; otherwise it is a protocol error.
module gnrc_rdstream_buf
  import gnrc_rdstream_pkg::*;
#(
  parameter int W  = 33,
  parameter int DP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int IW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = credit_w(DP);
  localparam logic [IW-1:0] LAST_IDX = IW'(DP - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DP);

  logic [W-1:0]  mem [DP];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= inc(wr_idx);
      if (do_pop)  rd_idx <= inc(rd_idx);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/gnrc_ram_rdstream.sv
// Burst reader for a fixed-latency RAM port; cmd->first ram_en 1 cycle, cmd->first dout_valid DELAY+2 cycles.
// Credits bound reads in flight plus buffered words, so dout_ready low stalls issue without dropping data.
module gnrc_ram_rdstream
  import gnrc_rdstream_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 10,
  parameter int DELAY  = 1,
  parameter int BUF_DP = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [AW:0]   cmd_len_i,
  output logic          ram_en_o,
  output logic [AW-1:0] ram_addr_o,
  input  logic [DW-1:0] ram_dout_i,
  output logic          dout_valid_o,
  input  logic          dout_ready_i,
  output logic [DW-1:0] dout_data_o,
  output logic          dout_last_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int CW = credit_w(BUF_DP);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(BUF_DP);
  localparam logic [AW:0]   LEN_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);

  state_e           state;
  logic [AW-1:0]    ptr;
  logic [AW:0]      remaining;
  logic [CW-1:0]    credits;
  logic             ram_last;
  logic [DELAY-1:0] pipe_vld;
  logic [DELAY-1:0] pipe_last;

  logic             issue;
  logic             issue_last;
  logic [AW-1:0]    issue_addr;
  logic             pop;
  logic             buf_empty;
  logic             buf_full;
  logic [DW:0]      buf_head;

  assign cmd_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign dout_valid_o = !buf_empty;
  assign dout_data_o  = buf_head[DW-1:0];
  assign dout_last_o  = buf_head[DW];
  assign pop          = dout_valid_o && dout_ready_i;

  // The first read is issued straight off the command handshake so ram_en_o follows it by one cycle.
  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = ptr;
    case (state)
      IDLE: begin
        issue      = cmd_valid_i && (cmd_len_i != '0);
        issue_addr = cmd_addr_i;
        issue_last = (cmd_len_i == LEN_ONE);
      end
      ISSUE: begin
        issue      = (credits != '0);
        issue_last = (remaining == LEN_ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      credits    <= CREDIT_MAX;
      ram_en_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_last   <= 1'b0;
      pipe_vld   <= '0;
      pipe_last  <= '0;
      done_o     <= 1'b0;
    end else begin
      ram_en_o <= issue;
      ram_last <= issue && issue_last;
      if (issue) ram_addr_o <= issue_addr;

      pipe_vld[0]  <= ram_en_o;
      pipe_last[0] <= ram_last;
      for (int i = 1; i < DELAY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end

      if (issue && !pop)      credits <= credits - CW'(1);
      else if (!issue && pop) credits <= credits + CW'(1);

      if (issue) begin
        ptr       <= issue_addr + ADDR_ONE;
        remaining <= ((state == IDLE) ? cmd_len_i : remaining) - LEN_ONE;
      end

      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_len_i == '0) done_o <= 1'b1;
            else                 state  <= issue_last ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue && issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && dout_last_o) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  gnrc_rdstream_buf #(
    .W  (DW + 1),
    .DP (BUF_DP)
  ) u_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (pipe_vld[DELAY-1]),
    .push_data ({pipe_last[DELAY-1], ram_dout_i}),
    .pop       (pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // A full buffer means every credit is held by a buffered word.
  a_credit_full: assert property (@(posedge clk_i) disable iff (rst_i) buf_full |-> (credits == '0));

endmodule
